// File: rtl/ms_sr_ff_sequencer_if.sv
// Command and response handshake bundle for the SR flip-flop sequencer.
// The master side issues commands and consumes results; the slave side is the controller.
interface ms_sr_ff_sequencer_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_q;
  logic [1:0] rsp_err;

  modport master (
    output cmd_valid, cmd_op, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_q, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, rsp_ready,
    output cmd_ready, rsp_valid, rsp_q, rsp_err
  );
endinterface

// File: rtl/ms_sr_ff_sequencer.sv
// Sequencer for one external master-slave SR flip-flop.
// Each accepted command drives S/R with setup time, then a full high/low pulse on the
// flip-flop clock, checks the master and slave outputs and returns the result.
// S and R are never both high: SET/RESET/HOLD use fixed codes and TOGGLE uses ~q/q.
module ms_sr_ff_sequencer #(
  parameter int SETUP_CYC = 2,
  parameter int HIGH_CYC  = 3,
  parameter int LOW_CYC   = 3,
  parameter int CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  ms_sr_ff_sequencer_if.slave       bus,
  output logic                      ff_S,
  output logic                      ff_R,
  output logic                      ff_clk,
  input  logic                      ff_mid_Q,
  input  logic                      ff_Q,
  input  logic                      ff_Qbar,
  output logic                      busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_CHECK,
    ST_RESP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             exp_q, exp_q_n;
  logic             mid_err, mid_err_n;
  logic             s_n, r_n, clk_n;
  logic             cmd_ready, cmd_ready_n;
  logic             rsp_valid, rsp_valid_n;
  logic             rsp_q, rsp_q_n;
  logic [1:0]       rsp_err, rsp_err_n;
  logic             busy_n;

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_q     = rsp_q;
  assign bus.rsp_err   = rsp_err;

  // Next-state and next-output logic; every registered output is computed from the next state
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    exp_q_n     = exp_q;
    mid_err_n   = mid_err;
    s_n         = ff_S;
    r_n         = ff_R;
    clk_n       = 1'b0;
    rsp_valid_n = rsp_valid;
    rsp_q_n     = rsp_q;
    rsp_err_n   = rsp_err;

    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          case (bus.cmd_op)
            2'b01: begin exp_q_n = 1'b1;   s_n = 1'b1;   r_n = 1'b0; end
            2'b10: begin exp_q_n = 1'b0;   s_n = 1'b0;   r_n = 1'b1; end
            2'b11: begin exp_q_n = ~ff_Q;  s_n = ~ff_Q;  r_n = ff_Q; end
            default: begin exp_q_n = ff_Q; s_n = 1'b0;   r_n = 1'b0; end
          endcase
          cnt_n   = CNT_W'(SETUP_CYC);
          state_n = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt == CNT_W'(1)) begin
          cnt_n   = CNT_W'(HIGH_CYC);
          clk_n   = 1'b1;
          state_n = ST_HIGH;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_HIGH: begin
        clk_n = 1'b1;
        if (cnt == CNT_W'(1)) begin
          mid_err_n = (ff_mid_Q != exp_q);
          cnt_n     = CNT_W'(LOW_CYC);
          clk_n     = 1'b0;
          state_n   = ST_LOW;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (cnt == CNT_W'(1)) begin
          s_n     = 1'b0;
          r_n     = 1'b0;
          state_n = ST_CHECK;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_CHECK: begin
        rsp_q_n     = ff_Q;
        rsp_err_n   = {(ff_Q != exp_q) | (ff_Qbar == ff_Q), mid_err};
        rsp_valid_n = 1'b1;
        state_n     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = ST_IDLE;
        end
      end
      default: begin
        s_n     = 1'b0;
        r_n     = 1'b0;
        state_n = ST_IDLE;
      end
    endcase

    cmd_ready_n = (state_n == ST_IDLE);
    busy_n      = (state_n != ST_IDLE);
  end

  // State, phase counter and registered outputs; reset aborts any sequence in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      exp_q     <= 1'b0;
      mid_err   <= 1'b0;
      ff_S      <= 1'b0;
      ff_R      <= 1'b0;
      ff_clk    <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_q     <= 1'b0;
      rsp_err   <= 2'b00;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      exp_q     <= exp_q_n;
      mid_err   <= mid_err_n;
      ff_S      <= s_n;
      ff_R      <= r_n;
      ff_clk    <= clk_n;
      cmd_ready <= cmd_ready_n;
      rsp_valid <= rsp_valid_n;
      rsp_q     <= rsp_q_n;
      rsp_err   <= rsp_err_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_ms_sr_ff_sequencer.sv
// Bench for the SR flip-flop sequencer: a behavioural master-slave FF with injectable faults,
// a response scoreboard and phase-timing checks.
module tb_ms_sr_ff_sequencer;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef struct packed {
    logic       q;
    logic [1:0] err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  logic ff_S, ff_R, ff_clk, busy;
  logic ff_mid_Q, ff_Q, ff_Qbar;

  int   vectors     = 0;
  int   miscompares = 0;
  bit   mon_en      = 1'b0;
  int   ff_mode     = 0;
  rsp_t sb[$];

  logic m_mid = 1'b0;
  logic m_q   = 1'b0;

  ms_sr_ff_sequencer_if bus();

  ms_sr_ff_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ff_S     (ff_S),
    .ff_R     (ff_R),
    .ff_clk   (ff_clk),
    .ff_mid_Q (ff_mid_Q),
    .ff_Q     (ff_Q),
    .ff_Qbar  (ff_Qbar),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Master-slave SR flip-flop: master follows S/R while ff_clk is high, slave copies master while low
  always @(posedge clk) begin
    if (ff_clk === 1'b1) begin
      if (ff_S === 1'b1)      m_mid <= 1'b1;
      else if (ff_R === 1'b1) m_mid <= 1'b0;
    end else begin
      m_q <= m_mid;
    end
  end

  // Mode 1 models outputs stuck at 0, mode 2 models Qbar shorted to Q
  assign ff_Q     = (ff_mode == 1) ? 1'b0 : m_q;
  assign ff_mid_Q = (ff_mode == 1) ? 1'b0 : m_mid;
  assign ff_Qbar  = (ff_mode == 2) ? m_q : ~m_q;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Waits for cmd_ready, predicts the response, and offers one command; returns just after the accept edge
  task automatic applyStimulus(input logic [1:0] op);
    int   n = 0;
    logic qp, e;
    rsp_t r;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      checkOutput("accept_timeout", 8'(0), 8'(1));
      return;
    end
    qp = ff_Q;
    case (op)
      OP_SET:    e = 1'b1;
      OP_RESET:  e = 1'b0;
      OP_TOGGLE: e = ~qp;
      default:   e = qp;
    endcase
    if (ff_mode == 1)      r = '{q: 1'b0, err: {e, e}};
    else if (ff_mode == 2) r = '{q: e, err: 2'b10};
    else                   r = '{q: e, err: 2'b00};
    sb.push_back(r);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'($urandom_range(0, 3));
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 8'(sb.size()), 8'(0));
  endtask

  // Response monitor and S/R exclusivity check, sampled just after each falling edge
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        checkOutput("sr_exclusive", 8'(ff_S & ff_R), 8'(0));
        if (rst === 1'b0 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_rsp", 8'(1), 8'(0));
          end else begin
            e = sb.pop_front();
            checkOutput("rsp_q", 8'(bus.rsp_q), 8'(e.q));
            checkOutput("rsp_err", 8'(bus.rsp_err), 8'(e.err));
          end
        end
      end
    end
  end

  // Directed sequence
  initial begin
    int   n;
    logic hq;
    logic [1:0] herr;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_HOLD;
    bus.rsp_ready = 1'b1;

    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cmd_ready", 8'(bus.cmd_ready), 8'(0));
    checkOutput("rst_ff_S", 8'(ff_S), 8'(0));
    checkOutput("rst_ff_R", 8'(ff_R), 8'(0));
    checkOutput("rst_ff_clk", 8'(ff_clk), 8'(0));
    checkOutput("rst_busy", 8'(busy), 8'(0));
    checkOutput("rst_rsp_valid", 8'(bus.rsp_valid), 8'(0));
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_cmd_ready", 8'(bus.cmd_ready), 8'(1));
    checkOutput("idle_busy", 8'(busy), 8'(0));
    mon_en = 1'b1;

    $display("[TB] SET with phase timing");
    applyStimulus(OP_SET);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("set_clk_T%0d", k), 8'(ff_clk), 8'((k >= 3 && k <= 5) ? 1 : 0));
      checkOutput($sformatf("set_S_T%0d", k), 8'(ff_S), 8'((k <= 8) ? 1 : 0));
      checkOutput($sformatf("set_R_T%0d", k), 8'(ff_R), 8'(0));
      checkOutput($sformatf("set_valid_T%0d", k), 8'(bus.rsp_valid), 8'((k == 10) ? 1 : 0));
      checkOutput($sformatf("set_ready_T%0d", k), 8'(bus.cmd_ready), 8'(0));
    end
    waitDrain();

    $display("[TB] TOGGLE from Q=1");
    applyStimulus(OP_TOGGLE);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checkOutput($sformatf("tog_S_T%0d", k), 8'(ff_S), 8'(0));
      checkOutput($sformatf("tog_R_T%0d", k), 8'(ff_R), 8'((k <= 8) ? 1 : 0));
    end
    waitDrain();
    applyStimulus(OP_TOGGLE);
    applyStimulus(OP_RESET);
    applyStimulus(OP_HOLD);
    applyStimulus(OP_SET);
    applyStimulus(OP_HOLD);
    waitDrain();

    $display("[TB] faulty flip-flop models");
    ff_mode = 1;
    applyStimulus(OP_SET);
    waitDrain();
    ff_mode = 2;
    applyStimulus(OP_SET);
    waitDrain();
    ff_mode = 0;

    $display("[TB] back-pressure on the response");
    bus.rsp_ready = 1'b0;
    applyStimulus(OP_RESET);
    n = 0;
    @(negedge clk);
    while (bus.rsp_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_valid_seen", 8'(bus.rsp_valid), 8'(1));
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput("bp_valid", 8'(bus.rsp_valid), 8'(1));
      checkOutput("bp_q", 8'(bus.rsp_q), 8'(0));
      checkOutput("bp_err", 8'(bus.rsp_err), 8'(0));
      checkOutput("bp_cmd_ready", 8'(bus.cmd_ready), 8'(0));
    end
    hq   = bus.rsp_q;
    herr = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_xfer_valid", 8'(bus.rsp_valid), 8'(0));
    checkOutput("post_xfer_cmd_ready", 8'(bus.cmd_ready), 8'(1));
    checkOutput("post_xfer_busy", 8'(busy), 8'(0));
    checkOutput("bp_stable_q", 8'(hq), 8'(0));
    checkOutput("bp_stable_err", 8'(herr), 8'(0));
    waitDrain();

    $display("[TB] reset during HIGH phase");
    applyStimulus(OP_SET);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    checkOutput("abort_pre_clk", 8'(ff_clk), 8'(1));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_clk", 8'(ff_clk), 8'(0));
    checkOutput("abort_S", 8'(ff_S), 8'(0));
    checkOutput("abort_R", 8'(ff_R), 8'(0));
    checkOutput("abort_busy", 8'(busy), 8'(0));
    checkOutput("abort_valid", 8'(bus.rsp_valid), 8'(0));
    rst = 1'b0;
    if (sb.size() != 0) void'(sb.pop_back());
    for (int k = 0; k < 15; k++) @(negedge clk);
    checkOutput("abort_no_rsp", 8'(bus.rsp_valid), 8'(0));
    applyStimulus(OP_HOLD);
    applyStimulus(OP_TOGGLE);
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
